pe_matrix_ctrl: RTL and testbench
=================================

Name: pe_matrix_ctrl

Overview:
Sequencer that drives the control side of the PE matrix. It loads one tile of weights, then one tile of input activations, into the matrix register files through a valid/ready upstream handshake. It then sweeps the read addresses and MAC enables for a 1-D stride-1 convolution. Each output position is presented to downstream through an oact_valid/oact_ready handshake. It is the initiator for every enable, write-enable and address input of the matrix.

Parameters:
WEIGHTS_ADDR_BITWIDTH, 4, width of the weight register-file address.
IACTS_ADDR_BITWIDTH, 5, width of the iact register-file address.
RD_LAT, 1, cycles from rd_addr to register-file dout.
MAC_LAT, 1, cycles from the last en_MAC_din to the accumulated result being ready for en_MAC_dout.

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle pulse; latches cfg_* and starts a tile when in IDLE; ignored otherwise.
cfg_k  in  WEIGHTS_ADDR_BITWIDTH+1  kernel length K, legal range 1..2^WEIGHTS_ADDR_BITWIDTH.
cfg_n_out  in  IACTS_ADDR_BITWIDTH+1  number of output positions N, legal range >=1.
in_valid  in  1  upstream word (weight row or iact column) is valid.
in_ready  out  1  controller accepts the upstream word.
en_regfile_wght, we_regfile_wght  out  1 each  weight register-file enable / write enable.
wr_addr_wght, rd_addr_wght  out  WEIGHTS_ADDR_BITWIDTH each  weight write / read address.
en_regfile_iact, we_regfile_iact  out  1 each  iact register-file enable / write enable.
wr_addr_iact, rd_addr_iact  out  IACTS_ADDR_BITWIDTH each  iact write / read address.
en_MAC_din, en_MAC_dout  out  1 each  MAC accumulate / output strobes.
oact_valid  out  1  matrix oacts hold output position oact_idx.
oact_ready  in  1  downstream accepts the output.
oact_idx  out  IACTS_ADDR_BITWIDTH  current output position p.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the tile completes.
cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE; every output is 0, including all addresses; all counters are 0.
- Configuration check at start: reject if cfg_k==0, cfg_n_out==0, cfg_k > 2^WEIGHTS_ADDR_BITWIDTH, or N+K-1 > 2^IACTS_ADDR_BITWIDTH.
  - On reject: cfg_err pulses the next cycle and the state stays IDLE.
- States: IDLE -> LOAD_W -> LOAD_I -> MAC -> DRAIN -> OUT_WAIT -> (MAC | FIN) -> IDLE.
- LOAD_W:
  - in_ready=1; each accepted word (in_valid&in_ready) increments wcnt.
  - The matrix registers its data inputs for one cycle, so write strobes follow acceptance by exactly 1 cycle: we_regfile_wght=en_regfile_wght=1 and wr_addr_wght=wcnt_old.
  - After K accepts, go to LOAD_I on the next cycle.
  - in_ready drops in the transition cycle, so no word is accepted into the wrong phase.
- LOAD_I: same mechanism with the iact strobes and address, for N+K-1 words.
  - The last iact write strobe occurs in the first MAC cycle; it uses wr_addr_iact while reads use rd_addr_iact, and both enables are high.
- MAC, for position p:
  - Issues K consecutive cycles with rd_addr_wght=k and rd_addr_iact=p+k, k=0..K-1, with en_regfile_* high.
  - en_MAC_din is the issue strobe delayed by RD_LAT, so it is high for exactly K cycles.
  - The first read of p=0 must not precede the final iact write; the read is issued at least one cycle after that write.
- DRAIN: waits until MAC_LAT cycles after the last en_MAC_din, then pulses en_MAC_dout for 1 cycle.
- OUT_WAIT:
  - oact_valid=1 with oact_idx=p, starting the cycle after en_MAC_dout.
  - oact_valid stays held until oact_ready; oact_idx is stable while held.
  - On handshake: if p==N-1 go to FIN, else p++ and go to MAC.
  - oact_ready asserted before valid has no effect.
- FIN: done=1 for one cycle, then IDLE.
- Upstream stalls: in_valid low produces no write strobe and the address holds.
- start while busy is ignored; it produces no cfg_err.
- Reset asserted mid-tile: asynchronous return to IDLE with all outputs 0; partial register-file contents are don't-care.
- Address arithmetic: p+k <= N+K-2 always fits IACTS_ADDR_BITWIDTH after the start check, so there is no wrap.
- Widths: counters are one bit wider than their addresses; addresses output the lower bits.

Test Plan:
- K=3, N=4, in_valid always 1: 3 weight writes at addresses 0,1,2, each one cycle after acceptance -> 6 iact writes at 0..5 -> 4 bursts reading iact addresses {0,1,2},{1,2,3},{2,3,4},{3,4,5} -> 4 en_MAC_dout pulses, oact_idx 0..3, then a single done pulse.
- Upstream gaps: in_valid toggling 1,0,0,1,… -> write count is still exactly K+N+K-1, addresses contiguous, no strobe during gap cycles.
- Downstream stall: oact_ready held low 5 cycles at p=1 -> oact_valid and oact_idx=1 stable, no en_MAC_din until the handshake.
- Illegal config: cfg_k=0; then K=4, N=30 with IACTS_ADDR_BITWIDTH=5 (33>32) -> cfg_err pulses each time, busy stays 0. Legal boundary K=16, N=17 (32 words) -> completes.
- Reset mid-tile: rst during MAC at p=2 -> all outputs 0 immediately. A fresh start afterwards runs a full correct tile from p=0.
- K=1, N=1, RD_LAT=2, MAC_LAT=3 -> en_MAC_din 2 cycles after the read, en_MAC_dout 3 cycles after en_MAC_din, one output, done.

Source files
------------

// File: rtl/pe_matrix_ctrl.sv
// pe_matrix_ctrl: control-side sequencer for the PE matrix.
//
// Loads one tile of K weights and then N+K-1 input activations into the matrix
// register files over a valid/ready upstream handshake. It then sweeps the read
// addresses and MAC enables of a 1-D stride-1 convolution, one output position
// at a time, and hands each result downstream over oact_valid/oact_ready.
//
// Ports:
//   clk, rst                    clock (posedge), asynchronous active-high reset
//   start, cfg_k, cfg_n_out     tile launch pulse and tile shape (latched at start)
//   in_valid / in_ready         upstream word handshake (weights, then iacts)
//   en/we_regfile_wght, wr/rd_addr_wght   weight register-file strobes and addresses
//   en/we_regfile_iact, wr/rd_addr_iact   iact register-file strobes and addresses
//   en_MAC_din, en_MAC_dout     MAC accumulate strobe / result output strobe
//   oact_valid, oact_ready, oact_idx      downstream handshake and output position
//   busy, done, cfg_err         status: not idle, tile complete pulse, rejected start
module pe_matrix_ctrl #(
  parameter int unsigned WEIGHTS_ADDR_BITWIDTH = 4,
  parameter int unsigned IACTS_ADDR_BITWIDTH   = 5,
  parameter int unsigned RD_LAT                = 1,
  parameter int unsigned MAC_LAT               = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WEIGHTS_ADDR_BITWIDTH:0]   cfg_k,
  input  logic [IACTS_ADDR_BITWIDTH:0]     cfg_n_out,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             en_regfile_wght,
  output logic                             we_regfile_wght,
  output logic [WEIGHTS_ADDR_BITWIDTH-1:0] wr_addr_wght,
  output logic [WEIGHTS_ADDR_BITWIDTH-1:0] rd_addr_wght,
  output logic                             en_regfile_iact,
  output logic                             we_regfile_iact,
  output logic [IACTS_ADDR_BITWIDTH-1:0]   wr_addr_iact,
  output logic [IACTS_ADDR_BITWIDTH-1:0]   rd_addr_iact,
  output logic                             en_MAC_din,
  output logic                             en_MAC_dout,
  output logic                             oact_valid,
  input  logic                             oact_ready,
  output logic [IACTS_ADDR_BITWIDTH-1:0]   oact_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int unsigned WAW         = WEIGHTS_ADDR_BITWIDTH;
  localparam int unsigned IAW         = IACTS_ADDR_BITWIDTH;
  localparam int unsigned KMax        = 2 ** WAW;
  localparam int unsigned IMax        = 2 ** IAW;
  // Cycles spent in DRAIN before the cycle that raises en_MAC_dout.
  localparam int unsigned DrainCycles = RD_LAT + MAC_LAT - 1;
  localparam logic [WAW:0] WOne       = {{WAW{1'b0}}, 1'b1};
  localparam logic [IAW:0] IOne       = {{IAW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadI,
    StMac,
    StDrain,
    StOutWait,
    StFin
  } state_e;

  state_e            state_q;
  logic [WAW:0]      k_q;
  logic [WAW:0]      wcnt_q;
  logic [WAW:0]      kcnt_q;
  logic [IAW:0]      n_q;
  logic [IAW:0]      icnt_q;
  logic [IAW:0]      p_q;
  logic [IAW:0]      ird_q;      // iact read pointer, p + k
  logic [7:0]        dcnt_q;
  logic              iss_q;      // read-issue strobe, aligned with the read address
  logic [RD_LAT-1:0] rd_pipe_q;  // issue strobe delayed to match register-file latency

  logic cfg_bad;
  logic accept;
  logic w_last;
  logic i_last;
  logic k_last;
  logic p_last;
  logic drain_end;

  always_comb begin
    cfg_bad   = (cfg_k == '0) || (cfg_n_out == '0) || (32'(cfg_k) > KMax) ||
                (32'(cfg_k) + 32'(cfg_n_out) > IMax + 1);
    accept    = in_valid & in_ready;
    w_last    = (wcnt_q + WOne) == k_q;
    // Last iact word when icnt + 1 == N + K - 1.
    i_last    = (32'(icnt_q) + 32'd2) == (32'(n_q) + 32'(k_q));
    k_last    = kcnt_q == (k_q - WOne);
    p_last    = p_q == (n_q - IOne);
    drain_end = 32'(dcnt_q) == DrainCycles;
  end

  assign en_MAC_din = rd_pipe_q[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      k_q             <= '0;
      wcnt_q          <= '0;
      kcnt_q          <= '0;
      n_q             <= '0;
      icnt_q          <= '0;
      p_q             <= '0;
      ird_q           <= '0;
      dcnt_q          <= '0;
      iss_q           <= 1'b0;
      rd_pipe_q       <= '0;
      in_ready        <= 1'b0;
      en_regfile_wght <= 1'b0;
      we_regfile_wght <= 1'b0;
      wr_addr_wght    <= '0;
      rd_addr_wght    <= '0;
      en_regfile_iact <= 1'b0;
      we_regfile_iact <= 1'b0;
      wr_addr_iact    <= '0;
      rd_addr_iact    <= '0;
      en_MAC_dout     <= 1'b0;
      oact_valid      <= 1'b0;
      oact_idx        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      en_regfile_wght <= 1'b0;
      we_regfile_wght <= 1'b0;
      en_regfile_iact <= 1'b0;
      we_regfile_iact <= 1'b0;
      iss_q           <= 1'b0;
      en_MAC_dout     <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
      rd_pipe_q       <= RD_LAT'({rd_pipe_q, iss_q});

      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              k_q      <= cfg_k;
              n_q      <= cfg_n_out;
              wcnt_q   <= '0;
              icnt_q   <= '0;
              p_q      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state_q  <= StLoadW;
            end
          end
        end

        StLoadW: begin
          // The matrix registers its data inputs, so the write lands one cycle
          // after acceptance at the pre-increment address.
          if (accept) begin
            en_regfile_wght <= 1'b1;
            we_regfile_wght <= 1'b1;
            wr_addr_wght    <= wcnt_q[WAW-1:0];
            wcnt_q          <= wcnt_q + WOne;
            if (w_last) begin
              in_ready <= 1'b0;
              state_q  <= StLoadI;
            end
          end
        end

        StLoadI: begin
          // in_ready is low only in the first cycle here (phase boundary).
          in_ready <= 1'b1;
          if (accept) begin
            en_regfile_iact <= 1'b1;
            we_regfile_iact <= 1'b1;
            wr_addr_iact    <= icnt_q[IAW-1:0];
            icnt_q          <= icnt_q + IOne;
            if (i_last) begin
              in_ready <= 1'b0;
              kcnt_q   <= '0;
              ird_q    <= p_q;
              state_q  <= StMac;
            end
          end
        end

        StMac: begin
          // Reads become visible next cycle, so the first read of a tile trails
          // the final iact write (visible in this cycle) by one cycle.
          en_regfile_wght <= 1'b1;
          en_regfile_iact <= 1'b1;
          iss_q           <= 1'b1;
          rd_addr_wght    <= kcnt_q[WAW-1:0];
          rd_addr_iact    <= ird_q[IAW-1:0];
          kcnt_q          <= kcnt_q + WOne;
          ird_q           <= ird_q + IOne;
          if (k_last) begin
            dcnt_q  <= '0;
            state_q <= StDrain;
          end
        end

        StDrain: begin
          if (drain_end) begin
            en_MAC_dout <= 1'b1;
            state_q     <= StOutWait;
          end else begin
            dcnt_q <= dcnt_q + 8'd1;
          end
        end

        StOutWait: begin
          // First cycle here carries en_MAC_dout; valid rises after it.
          if (!oact_valid) begin
            oact_valid <= 1'b1;
            oact_idx   <= p_q[IAW-1:0];
          end else if (oact_ready) begin
            oact_valid <= 1'b0;
            if (p_last) begin
              done    <= 1'b1;
              state_q <= StFin;
            end else begin
              p_q     <= p_q + IOne;
              ird_q   <= p_q + IOne;
              kcnt_q  <= '0;
              state_q <= StMac;
            end
          end
        end

        StFin: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_matrix_ctrl.sv
// Directed self-checking bench for pe_matrix_ctrl. A second instance with longer
// read and MAC latencies checks strobe spacing on a single-output tile.
module tb_pe_matrix_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       start, in_valid, oact_ready;
  logic [4:0] cfg_k;
  logic [5:0] cfg_n_out;
  logic       in_ready, en_regfile_wght, we_regfile_wght, en_regfile_iact, we_regfile_iact;
  logic       en_MAC_din, en_MAC_dout, oact_valid, busy, done, cfg_err;
  logic [3:0] wr_addr_wght, rd_addr_wght;
  logic [4:0] wr_addr_iact, rd_addr_iact, oact_idx;

  // RD_LAT=2, MAC_LAT=3 instance.
  logic       start_b, in_valid_b, oact_ready_b;
  logic [4:0] cfg_k_b;
  logic [5:0] cfg_n_b;
  logic       in_ready_b, en_regfile_wght_b, we_regfile_wght_b, en_regfile_iact_b;
  logic       we_regfile_iact_b, en_MAC_din_b, en_MAC_dout_b, oact_valid_b, busy_b;
  logic       done_b, cfg_err_b;
  logic [3:0] wr_addr_wght_b, rd_addr_wght_b;
  logic [4:0] wr_addr_iact_b, rd_addr_iact_b, oact_idx_b;

  pe_matrix_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_n_out(cfg_n_out),
    .in_valid(in_valid), .in_ready(in_ready),
    .en_regfile_wght(en_regfile_wght), .we_regfile_wght(we_regfile_wght),
    .wr_addr_wght(wr_addr_wght), .rd_addr_wght(rd_addr_wght),
    .en_regfile_iact(en_regfile_iact), .we_regfile_iact(we_regfile_iact),
    .wr_addr_iact(wr_addr_iact), .rd_addr_iact(rd_addr_iact),
    .en_MAC_din(en_MAC_din), .en_MAC_dout(en_MAC_dout),
    .oact_valid(oact_valid), .oact_ready(oact_ready), .oact_idx(oact_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  pe_matrix_ctrl #(.RD_LAT(2), .MAC_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cfg_k(cfg_k_b), .cfg_n_out(cfg_n_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .en_regfile_wght(en_regfile_wght_b), .we_regfile_wght(we_regfile_wght_b),
    .wr_addr_wght(wr_addr_wght_b), .rd_addr_wght(rd_addr_wght_b),
    .en_regfile_iact(en_regfile_iact_b), .we_regfile_iact(we_regfile_iact_b),
    .wr_addr_iact(wr_addr_iact_b), .rd_addr_iact(rd_addr_iact_b),
    .en_MAC_din(en_MAC_din_b), .en_MAC_dout(en_MAC_dout_b),
    .oact_valid(oact_valid_b), .oact_ready(oact_ready_b), .oact_idx(oact_idx_b),
    .busy(busy_b), .done(done_b), .cfg_err(cfg_err_b)
  );

  logic [33:0] outs;
  assign outs = {in_ready, en_regfile_wght, we_regfile_wght, wr_addr_wght, rd_addr_wght,
                 en_regfile_iact, we_regfile_iact, wr_addr_iact, rd_addr_iact, en_MAC_din,
                 en_MAC_dout, oact_valid, oact_idx, busy, done, cfg_err};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Event log for the default instance.
  int wq[$], iq[$], wrq[$], irq[$], oq[$];
  int cyc, viol, acc_mis, din_mis, lat_mis, din_cnt, dout_cnt, done_cnt, err_cnt;
  int busy_seen, stall_cnt, acc_cnt, first_rd, last_iw, last_din, dout_cyc;
  bit prev_acc, prev_iss, prev_valid, prev_ready, rd_w, rd_i;
  logic [4:0] prev_idx;

  task automatic clear_log();
    wq.delete(); iq.delete(); wrq.delete(); irq.delete(); oq.delete();
    cyc = 0; viol = 0; acc_mis = 0; din_mis = 0; lat_mis = 0; din_cnt = 0; dout_cnt = 0;
    done_cnt = 0; err_cnt = 0; busy_seen = 0; stall_cnt = 0; acc_cnt = 0;
    first_rd = -1; last_iw = 0; last_din = -100; dout_cyc = -100;
    prev_acc = 0; prev_iss = 0; prev_valid = 0; prev_ready = 0; prev_idx = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (we_regfile_wght) begin
        wq.push_back(int'(wr_addr_wght));
        if (!en_regfile_wght) viol++;
      end
      if (we_regfile_iact) begin
        iq.push_back(int'(wr_addr_iact));
        if (!en_regfile_iact) viol++;
        last_iw = cyc;
      end
      rd_w = en_regfile_wght && !we_regfile_wght;
      rd_i = en_regfile_iact && !we_regfile_iact;
      if (rd_w != rd_i) viol++;
      if (rd_i) begin
        irq.push_back(int'(rd_addr_iact));
        wrq.push_back(int'(rd_addr_wght));
        if (first_rd < 0) first_rd = cyc;
      end
      if (en_MAC_din != prev_iss) din_mis++;
      if (en_MAC_din) begin
        din_cnt++;
        last_din = cyc;
      end
      if (en_MAC_dout) begin
        dout_cnt++;
        if (cyc - last_din != 1) lat_mis++;
        dout_cyc = cyc;
      end
      if (oact_valid && !prev_valid && (cyc - dout_cyc != 1)) lat_mis++;
      if (prev_valid && !prev_ready && (!oact_valid || oact_idx != prev_idx)) viol++;
      if (oact_valid && en_MAC_din) viol++;
      if (oact_valid && oact_ready) oq.push_back(int'(oact_idx));
      if (oact_valid && !oact_ready) stall_cnt++;
      if (done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (busy) busy_seen++;
      // A write strobe must appear exactly one cycle after each acceptance.
      if ((we_regfile_wght || we_regfile_iact) != prev_acc) acc_mis++;
      if (in_valid && in_ready) acc_cnt++;
      prev_acc   = in_valid && in_ready;
      prev_iss   = rd_i;
      prev_valid = oact_valid;
      prev_ready = oact_ready;
      prev_idx   = oact_idx;
    end
  end

  // Event log for the long-latency instance.
  int cyc_b, rd_cnt_b, rd_cyc_b, din_cnt_b, din_cyc_b, dout_cnt_b, dout_cyc_b;
  int val_cyc_b, done_cnt_b, idx_b;

  always @(negedge clk) begin
    if (!rst) begin
      cyc_b++;
      if (en_regfile_iact_b && !we_regfile_iact_b) begin
        rd_cnt_b++;
        rd_cyc_b = cyc_b;
      end
      if (en_MAC_din_b) begin
        din_cnt_b++;
        din_cyc_b = cyc_b;
      end
      if (en_MAC_dout_b) begin
        dout_cnt_b++;
        dout_cyc_b = cyc_b;
      end
      if (oact_valid_b && val_cyc_b < 0) begin
        val_cyc_b = cyc_b;
        idx_b     = int'(oact_idx_b);
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic check_tile(input int k, input int n, input int stalls);
    check("w_wr_cnt", wq.size(), k);
    for (int i = 0; i < k; i++) check("w_wr_addr", (i < wq.size()) ? wq[i] : -1, i);
    check("i_wr_cnt", iq.size(), n + k - 1);
    for (int i = 0; i < n + k - 1; i++) check("i_wr_addr", (i < iq.size()) ? iq[i] : -1, i);
    check("accepts", acc_cnt, 2 * k + n - 1);
    check("rd_cnt", irq.size(), n * k);
    for (int p = 0; p < n; p++) begin
      for (int j = 0; j < k; j++) begin
        check("i_rd_addr", (p * k + j < irq.size()) ? irq[p * k + j] : -1, p + j);
        check("w_rd_addr", (p * k + j < wrq.size()) ? wrq[p * k + j] : -1, j);
      end
    end
    check("din_cnt", din_cnt, n * k);
    check("dout_cnt", dout_cnt, n);
    check("oact_cnt", oq.size(), n);
    for (int p = 0; p < n; p++) check("oact_idx", (p < oq.size()) ? oq[p] : -1, p);
    check("done_cnt", done_cnt, 1);
    check("cfg_err_cnt", err_cnt, 0);
    check("rd_after_wr", int'(first_rd > last_iw), 1);
    check("protocol_viol", viol, 0);
    check("strobe_vs_accept", acc_mis, 0);
    check("din_latency", din_mis, 0);
    check("dout_latency", lat_mis, 0);
    check("stall_cycles", stall_cnt, stalls);
    check("busy_after", int'(busy), 0);
  endtask

  task automatic run_tile(input int k, input int n, input bit gaps, input int stall_p,
                          input bit poke);
    int held;
    int fin;
    held = 0;
    fin  = 0;
    clear_log();
    @(posedge clk); #1;
    cfg_k = 5'(k); cfg_n_out = 6'(n); start = 1'b1; in_valid = 1'b1; oact_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3000 && fin == 0; c++) begin
      in_valid = gaps ? (c % 3 == 0) : 1'b1;
      start    = poke && (c == 20);
      cfg_k    = start ? 5'd0 : 5'(k);
      if (oact_valid && int'(oact_idx) == stall_p && held < 5) begin
        oact_ready = 1'b0;
        held++;
      end else begin
        oact_ready = 1'b1;
      end
      @(posedge clk); #1;
      fin = (done_cnt != 0) ? 1 : 0;
    end
    check("tile_timeout", fin, 1);
    start = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_tile(k, n, (stall_p >= 0) ? 5 : 0);
  endtask

  task automatic try_bad(input int k, input int n);
    clear_log();
    @(posedge clk); #1;
    cfg_k = 5'(k); cfg_n_out = 6'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("cfg_err_pulse", err_cnt, 1);
    check("cfg_err_busy", busy_seen, 0);
  endtask

  initial begin
    int hit;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; oact_ready = 1'b0;
    cfg_k = '0; cfg_n_out = '0;
    start_b = 1'b0; in_valid_b = 1'b0; oact_ready_b = 1'b1; cfg_k_b = '0; cfg_n_b = '0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_lo", int'(outs[31:0]), 0);
    check("reset_outs_hi", int'({30'd0, outs[33:32]}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_outs_lo", int'(outs[31:0]), 0);

    run_tile(3, 4, 1'b0, -1, 1'b0);   // basic
    run_tile(3, 4, 1'b1, -1, 1'b0);   // upstream gaps
    run_tile(3, 4, 1'b0, 1, 1'b1);    // downstream stall at p=1, start while busy

    try_bad(0, 4);
    try_bad(4, 30);
    try_bad(17, 1);
    try_bad(2, 0);

    run_tile(16, 17, 1'b0, -1, 1'b0); // largest legal tile

    // Reset while sweeping p=2.
    clear_log();
    @(posedge clk); #1;
    cfg_k = 5'd3; cfg_n_out = 6'd4; start = 1'b1; in_valid = 1'b1; oact_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 500 && hit == 0; c++) begin
      @(posedge clk); #1;
      hit = (en_regfile_iact && !we_regfile_iact && rd_addr_wght == 4'd0 &&
             rd_addr_iact == 5'd2) ? 1 : 0;
    end
    check("rst_reach_p2", hit, 1);
    rst = 1'b1;
    #1;
    check("midrst_outs_lo", int'(outs[31:0]), 0);
    check("midrst_outs_hi", int'({30'd0, outs[33:32]}), 0);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    clear_log();
    run_tile(3, 4, 1'b0, -1, 1'b0);

    // Long-latency instance, K=1, N=1.
    cyc_b = 0; rd_cnt_b = 0; rd_cyc_b = -100; din_cnt_b = 0; din_cyc_b = -100;
    dout_cnt_b = 0; dout_cyc_b = -100; val_cyc_b = -1; done_cnt_b = 0; idx_b = -1;
    @(posedge clk); #1;
    cfg_k_b = 5'd1; cfg_n_b = 6'd1; start_b = 1'b1; in_valid_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 200 && done_cnt_b == 0; c++) begin
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b_done", done_cnt_b, 1);
    check("b_rd_cnt", rd_cnt_b, 1);
    check("b_din_cnt", din_cnt_b, 1);
    check("b_dout_cnt", dout_cnt_b, 1);
    check("b_din_lat", din_cyc_b - rd_cyc_b, 2);
    check("b_dout_lat", dout_cyc_b - din_cyc_b, 3);
    check("b_valid_lat", val_cyc_b - dout_cyc_b, 1);
    check("b_oact_idx", idx_b, 0);
    check("b_busy_after", int'(busy_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
